pe_param: RTL

// - Parametrised systolic-array processing element. Successor to the fixed 8/20-bit PE_256 instance.
// - One MAC per valid beat. Double-buffered c1/c2 accumulators, and dataflow selected per beat:

---
 rtl/pe_param.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pe_param.sv
// Parametrised systolic-array PE: double-buffered c1/c2 accumulators, per-beat OS/WS dataflow.
// Optional macro PE_SAT_EN makes the out_c clip saturate; otherwise it wraps to OUT_W bits.
module pe_param #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 20,
    parameter int ACC_W   = 32,
    parameter int SHIFT_W = 5,
    parameter int ID_W    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [IN_W-1:0]   in_a,
    input  logic signed [OUT_W-1:0]  in_b,
    input  logic signed [OUT_W-1:0]  in_d,
    input  logic                     in_dataflow,
    input  logic                     in_propagate,
    input  logic [SHIFT_W-1:0]       in_shift,
    input  logic [ID_W-1:0]          in_id,
    input  logic                     in_last,
    output logic                     out_valid,
    output logic signed [IN_W-1:0]   out_a,
    output logic signed [OUT_W-1:0]  out_b,
    output logic signed [OUT_W-1:0]  out_c,
    output logic                     out_dataflow,
    output logic                     out_propagate,
    output logic [SHIFT_W-1:0]       out_shift,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_last
);

    logic signed [ACC_W-1:0] c1;
    logic signed [ACC_W-1:0] c2;
    logic                    last_prop;

    logic                    flip;
    logic [SHIFT_W-1:0]      shift_amt;
    logic signed [ACC_W-1:0] drain_bank;
    logic signed [ACC_W-1:0] acc_bank;
    logic signed [ACC_W-1:0] preload;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [IN_W-1:0]  ws_weight;
    logic signed [OUT_W-1:0] ws_sum;
    logic signed [OUT_W-1:0] b_next;
    logic signed [OUT_W-1:0] c_next;

    // Round-half-up arithmetic shift; the +1 bit keeps the rounding add from overflowing.
    function automatic logic signed [ACC_W-1:0] round_shift(
        input logic signed [ACC_W-1:0] x,
        input logic [SHIFT_W-1:0]      s
    );
        logic signed [ACC_W:0]   wide;
        logic signed [ACC_W-1:0] res;
        wide = (ACC_W+1)'(x) + ((ACC_W+1)'(1) <<< (s - 1'b1));
        if (s == '0)
            res = x;
        else if (int'(s) >= ACC_W)
            res = {ACC_W{x[ACC_W-1]}};
        else
            res = ACC_W'(wide >>> s);
        return res;
    endfunction

    assign flip       = (in_propagate != last_prop);
    assign shift_amt  = flip ? in_shift : '0;

    // The propagate bit names the bank being drained and preloaded; the other one works.
    assign drain_bank = in_propagate ? c1 : c2;
    assign acc_bank   = in_propagate ? c2 : c1;

    assign prod       = ACC_W'(in_a) * ACC_W'(in_b);
    assign preload    = in_dataflow ? ACC_W'(in_b) : ACC_W'(in_d);
    assign acc_next   = in_dataflow ? acc_bank : acc_bank + prod;
    assign ws_weight  = acc_bank[IN_W-1:0];
    assign ws_sum     = in_d + OUT_W'(in_a) * OUT_W'(ws_weight);
    assign b_next     = in_dataflow ? ws_sum : in_b;

`ifdef PE_SAT_EN
    localparam logic signed [ACC_W-1:0] CLIP_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] CLIP_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic signed [ACC_W-1:0] drain_val;

    always_comb begin
        drain_val = in_dataflow ? drain_bank : round_shift(drain_bank, shift_amt);
        if (drain_val > CLIP_MAX)
            c_next = OUT_W'(CLIP_MAX);
        else if (drain_val < CLIP_MIN)
            c_next = OUT_W'(CLIP_MIN);
        else
            c_next = OUT_W'(drain_val);
    end
`else
    assign c_next = OUT_W'(in_dataflow ? drain_bank : round_shift(drain_bank, shift_amt));
`endif

    // Bubbles only clear out_valid; banks and payload outputs keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1            <= '0;
            c2            <= '0;
            last_prop     <= 1'b0;
            out_valid     <= 1'b0;
            out_a         <= '0;
            out_b         <= '0;
            out_c         <= '0;
            out_dataflow  <= 1'b0;
            out_propagate <= 1'b0;
            out_shift     <= '0;
            out_id        <= '0;
            out_last      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                last_prop     <= in_propagate;
                out_a         <= in_a;
                out_b         <= b_next;
                out_c         <= c_next;
                out_dataflow  <= in_dataflow;
                out_propagate <= in_propagate;
                out_shift     <= in_shift;
                out_id        <= in_id;
                out_last      <= in_last;
                if (in_propagate) begin
                    c1 <= preload;
                    c2 <= acc_next;
                end else begin
                    c2 <= preload;
                    c1 <= acc_next;
                end
            end
        end
    end

endmodule
